// File: rtl/hd_dma_if.sv
// Disk and memory bus bundle for hd_dma.
// The master side is the DMA engine; the slave side is the disk/memory pair.
interface hd_dma_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] hd_address;
  logic [DATA_WIDTH-1:0] hd_input_data;
  logic                  hd_write_flag;
  logic [DATA_WIDTH-1:0] hd_output;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_flag;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output hd_address, hd_input_data, hd_write_flag,
    output mem_address, mem_write_data, mem_write_flag,
    input  hd_output, mem_read_data
  );

  modport slave (
    input  hd_address, hd_input_data, hd_write_flag,
    input  mem_address, mem_write_data, mem_write_flag,
    output hd_output, mem_read_data
  );
endinterface

// File: rtl/hd_dma.sv
// Word-by-word DMA between a disk and memory, 3 cycles per word (RD, WAIT, WR).
// Optional running checksum of written words: define HD_DMA_CHECKSUM_EN.
module hd_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12,
  parameter int DISK_SIZE  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  direction,
  input  logic [DATA_WIDTH-1:0] src_base,
  input  logic [DATA_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum,
  hd_dma_if.master              bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [DATA_WIDTH:0] DISK_LIMIT = (DATA_WIDTH+1)'(DISK_SIZE);

  logic [2:0]            state;
  logic                  dir_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] src_ptr;
  logic [DATA_WIDTH-1:0] dst_ptr;
  logic [LEN_WIDTH-1:0]  count;

  logic [DATA_WIDTH-1:0] disk_base;
  logic [DATA_WIDTH:0]   disk_end;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] wr_data;

  // Bounds check is one bit wider so base + length cannot wrap past the limit.
  always_comb begin
    disk_base = direction ? dst_base : src_base;
    disk_end  = {1'b0, disk_base} + (DATA_WIDTH+1)'(length);
    overflow  = disk_end > DISK_LIMIT;
    wr_data   = dir_q ? bus.mem_read_data : bus.hd_output;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dir_q   <= direction;
            src_ptr <= src_base;
            dst_ptr <= dst_base;
            count   <= length;
            err_q   <= overflow;
            state   <= (overflow || length == '0) ? S_FIN : S_RD;
          end
        end
        S_RD:   state <= S_WAIT;
        S_WAIT: state <= S_WR;
        S_WR: begin
          src_ptr <= src_ptr + 1'b1;
          dst_ptr <= dst_ptr + 1'b1;
          count   <= count - 1'b1;
          // count still holds the pre-decrement value here
          state   <= (count == LEN_WIDTH'(1)) ? S_FIN : S_RD;
        end
        S_FIN: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every bus output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    bus.hd_address     = '0;
    bus.hd_input_data  = '0;
    bus.hd_write_flag  = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_write_flag = 1'b0;
    if (state == S_RD || state == S_WAIT) begin
      if (dir_q) bus.mem_address = src_ptr;
      else       bus.hd_address  = src_ptr;
    end else if (state == S_WR) begin
      if (dir_q) begin
        bus.hd_address    = dst_ptr;
        bus.hd_input_data = wr_data;
        bus.hd_write_flag = 1'b1;
      end else begin
        bus.mem_address    = dst_ptr;
        bus.mem_write_data = wr_data;
        bus.mem_write_flag = 1'b1;
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_FIN);
  assign error = err_q;

`ifdef HD_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state == S_IDLE && start) begin
      sum_q <= '0;
    end else if (state == S_WR) begin
      sum_q <= sum_q + wr_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/hd_dma.md
HD_DMA -- requirements
Module: hd_dma

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every data word and address bus.
REQ-002 SHALL have parameter LEN_WIDTH, default 12: width of transfer length.
REQ-003 SHALL have parameter DISK_SIZE, default 4096: number of valid disk words.
REQ-004 SHALL have ports: clk  input  1  single clock, all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-007 direction  input  1  0 = load (disk to memory), 1 = store (memory to disk).
REQ-008 src_base, dst_base  input  DATA_WIDTH each  first source / destination word address.
REQ-009 length  input  LEN_WIDTH  number of words to move.
REQ-010 hd_address, hd_input_data  output  DATA_WIDTH each  disk address / disk write data.
REQ-011 hd_write_flag  output  1  disk write strobe.
REQ-012 hd_output  input  DATA_WIDTH  disk read data, valid one clk after hd_address is stable.
REQ-013 mem_address, mem_write_data  output  DATA_WIDTH each; mem_write_flag  output  1.
REQ-014 mem_read_data  input  DATA_WIDTH  memory read data, same one-cycle latency.
REQ-015 busy, done, error  output  1 each; checksum  output  DATA_WIDTH.

Function
REQ-016 SHALL implement states IDLE, RD, WAIT, WR, FIN.
REQ-017 IDLE: on start=1, latch direction, src_base, dst_base and length, then go to RD; start=0 stays in IDLE.
REQ-018 Accept cycle with length=0 SHALL go to FIN with no write strobe.
REQ-019 Accept cycle SHALL set error and go to FIN, with no write strobe, if disk-side base + length > DISK_SIZE (computed 1 bit wider than DATA_WIDTH). The disk-side base is src for a load and dst for a store.
REQ-020 RD SHALL drive the source-side address (hd_address for a load, mem_address for a store) = src pointer, then go to WAIT.
REQ-021 WAIT SHALL hold addresses, then go to WR.
REQ-022 WR SHALL drive the destination address = dst pointer and data = read data sampled in this state, and assert the destination write flag for exactly this one cycle.
REQ-023 WR SHALL then increment both pointers, decrement the remaining count, and go to RD if count > 0, else to FIN.
REQ-024 Each word SHALL take exactly 3 cycles; a transfer of N>0 words SHALL keep busy high for 3N+1 cycles.
REQ-025 FIN SHALL assert done for exactly one cycle, with error still valid, then return to IDLE and clear error.
REQ-026 busy SHALL be high in RD, WAIT, WR and FIN, and low in IDLE.
REQ-027 start while busy SHALL be ignored, with no queuing.
REQ-028 The non-destination write flag SHALL never assert, and both write flags SHALL be 0 outside WR.
REQ-029 Pointers SHALL wrap modulo 2^DATA_WIDTH; REQ-019 guarantees disk-side pointers stay below DISK_SIZE.

Reset
REQ-030 Reset asserted SHALL force state IDLE and all outputs 0, including addresses, data, flags, busy, done, error and checksum.
REQ-031 Reset during a transfer SHALL abort it immediately, with no further write strobe and no done pulse.
REQ-032 After reset deasserts, the first clk edge with start=1 SHALL be accepted.

Configuration
REQ-033 With macro HD_DMA_CHECKSUM_EN defined, checksum SHALL be cleared on accept and add each word written in WR, modulo 2^DATA_WIDTH.
REQ-034 checksum SHALL hold its value from FIN until the next accept.
REQ-035 Without HD_DMA_CHECKSUM_EN, checksum SHALL be constant 0 and no adder is synthesized.

Verification
REQ-036 Load, src=0, dst=100, length=3, disk[0..2]=A,B,C -> mem[100..102]=A,B,C; 3 mem_write_flag pulses; busy high 10 cycles; done 1 cycle; checksum=A+B+C with macro.
REQ-037 Store, src=200, dst=4093, length=3 -> disk[4093..4095] written, error=0.
REQ-038 Store, dst=4094, length=3 -> error=1 with done in the cycle after accept; no write strobe.
REQ-039 length=0 -> done the cycle after accept; no writes; busy high exactly 1 cycle.
REQ-040 start pulsed again during the WAIT of word 1 -> ignored; exactly the original word count written.
REQ-041 Reset asserted in the WR of word 2 of 4 -> flags drop immediately; no done; a new start afterwards completes normally.
